sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Round-robin arbiter that shares one bank of set/reset status flags between N_REQ requesters.
- Each requester issues set/clear commands against a flag index using a valid/ready handshake.
- One command is granted per clock. The granted command updates the flag bank on that edge.
- Sits between control agents (FSMs, interrupt sources) and the flags they share. Replaces ad-hoc per-agent latches with a clocked, arbitrated flag register.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- N_FLAG, 8, number of flags in the bank (1..2**IDX_W).
- IDX_W, 3, width of each flag index field.
- GNT_W, 2, width of grant_id (ceil(log2(N_REQ))).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester command valid.
- req_set  in  N_REQ  per-requester set command.
- req_clr  in  N_REQ  per-requester clear command.
- req_idx  in  N_REQ*IDX_W  per-requester flag index; requester i uses bits [i*IDX_W +: IDX_W].
- req_ready  out  N_REQ  grant/accept, one-hot or zero, combinational.
- err_clr  in  1  clears the sticky error flags.
- flags  out  N_FLAG  flag bank state, registered.
- gnt_vld  out  1  registered: a command was accepted in the previous cycle.
- gnt_id  out  GNT_W  registered: id of the last accepted requester.
- err_illegal  out  1  sticky: accepted command had set=1 and clr=1.
- err_range  out  1  sticky: accepted command had req_idx >= N_FLAG.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - flags=0, gnt_vld=0, gnt_id=0, err_illegal=0, err_range=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
  - req_ready=0 while rst_n=0.
  - Deassertion is sampled synchronously. The first grant can occur in the first cycle after rst_n is high at a clock edge.
- Arbitration (combinational):
  - Search req_valid starting at (last+1) mod N_REQ, wrapping.
  - The first valid requester w gets req_ready[w]=1; all other ready bits are 0.
  - If no req_valid, req_ready=0.
- Transfer: a command transfers when req_valid[w] and req_ready[w] are both 1. On that clk edge:
  - last <= w.
  - gnt_vld <= 1, gnt_id <= w.
  - The command is applied to the flag bank.
- No-transfer edge: gnt_vld <= 0, gnt_id holds.
- Command decode, using idx = req_idx of w:
  - set=1, clr=0, idx<N_FLAG: flags[idx] <= 1.
  - set=0, clr=1, idx<N_FLAG: flags[idx] <= 0.
  - set=0, clr=0: accepted no-op; flags hold; no error.
  - set=1, clr=1: accepted; flags unchanged (never X); err_illegal <= 1.
  - idx >= N_FLAG: accepted; flags unchanged; err_range <= 1. Illegal and range errors may both set on the same command.
- Latency: a command accepted at edge k is visible on flags after edge k. Back-to-back grants are allowed: one per cycle, no bubble.
- Fairness: a requester holding valid is served within N_REQ cycles. A requester just granted has lowest priority next cycle.
- Flag writes: only one writer per cycle, so flag-level write conflicts cannot occur.
- err_clr: clears both sticky errors at the edge. If a new error occurs on the same edge, the new error wins and the bit stays 1.
- Requesters may change set/clr/idx while valid and not yet ready. Only the values at the transfer edge matter.
- Reset mid-operation: all state clears immediately. Any in-flight grant is discarded and its flag update is lost.

Optional Feature:
- Macro: SR_FLAG_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits.
  - Counts accepted commands that raise any error (+1 per command, even if both errors are raised).
  - Saturates at 8'hFF.
  - Reset value 0. err_clr zeroes it. If an error occurs on the same edge as err_clr, err_cnt becomes 1.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-clock -> flags=0, err_*=0, gnt_vld=0, req_ready=0 without waiting for a clock edge.
- Single set: req_valid=4'b0001, req_set[0]=1, idx=3 -> req_ready=4'b0001 same cycle; next edge flags=8'h08, gnt_vld=1, gnt_id=0.
- Fairness: req_valid=4'b1111 held, requester i sets idx=i -> grants 0,1,2,3,0 on consecutive edges; flags=8'h0F after 4 edges.
- Illegal: flags[2]=1; requester 1 sends set=1, clr=1, idx=2 -> accepted, flags[2] stays 1, err_illegal=1. Then err_clr pulse -> err_illegal=0 (err_cnt=0 if enabled).
- Range (N_FLAG=6): idx=7, set=1 -> accepted, flags unchanged, err_range=1. Pulse err_clr on the same edge as another range error -> err_range stays 1.
- Reset mid-stream: 4 requesters active, flags=8'h0F; assert rst_n=0 -> flags=0 immediately. After release, requester 0 is granted first.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/clear command per clock onto a shared flag bank.
// Optional macro SR_FLAG_ERR_CNT_EN adds an 8-bit saturating error-command counter (err_cnt).
module sr_flag_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_FLAG = 8,
  parameter int IDX_W  = 3,
  parameter int GNT_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_set,
  input  logic [N_REQ-1:0]       req_clr,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   err_clr,
  output logic [N_FLAG-1:0]      flags,
  output logic                   gnt_vld,
  output logic [GNT_W-1:0]       gnt_id,
  output logic                   err_illegal,
  output logic                   err_range
`ifdef SR_FLAG_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  logic [GNT_W-1:0]  last_q, last_d;
  logic [N_FLAG-1:0] flags_q, flags_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [GNT_W-1:0]  gnt_id_q, gnt_id_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_range_q, err_range_d;

  logic [GNT_W-1:0]  win;
  logic              found, xfer;
  logic              cmd_set, cmd_clr, in_range, hit_ill, hit_rng;
  logic [IDX_W-1:0]  cmd_idx;

  // Two passes: requesters above the last winner first, then wrap to the rest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last_q))) begin
        found = 1'b1;
        win   = GNT_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i <= int'(last_q))) begin
        found = 1'b1;
        win   = GNT_W'(i);
      end
    end
  end

  always_comb begin
    xfer      = found & rst_n;
    req_ready = '0;
    cmd_set   = 1'b0;
    cmd_clr   = 1'b0;
    cmd_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(win) == i) begin
        req_ready[i] = xfer;
        cmd_set      = req_set[i];
        cmd_clr      = req_clr[i];
        cmd_idx      = req_idx[i*IDX_W +: IDX_W];
      end
    end
    in_range = (int'(cmd_idx) < N_FLAG);
    hit_ill  = xfer & cmd_set & cmd_clr;
    hit_rng  = xfer & ~in_range;
  end

  // Only a clean, in-range set or clear touches the bank; errored commands leave it intact.
  always_comb begin
    flags_d = flags_q;
    if (xfer && in_range && !(cmd_set && cmd_clr)) begin
      for (int f = 0; f < N_FLAG; f++) begin
        if (int'(cmd_idx) == f) begin
          if (cmd_set)      flags_d[f] = 1'b1;
          else if (cmd_clr) flags_d[f] = 1'b0;
        end
      end
    end
    last_d        = xfer ? win : last_q;
    gnt_vld_d     = xfer;
    gnt_id_d      = xfer ? win : gnt_id_q;
    err_illegal_d = (err_illegal_q & ~err_clr) | hit_ill;
    err_range_d   = (err_range_q & ~err_clr) | hit_rng;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= GNT_W'(N_REQ - 1);
      flags_q       <= '0;
      gnt_vld_q     <= 1'b0;
      gnt_id_q      <= '0;
      err_illegal_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      last_q        <= last_d;
      flags_q       <= flags_d;
      gnt_vld_q     <= gnt_vld_d;
      gnt_id_q      <= gnt_id_d;
      err_illegal_q <= err_illegal_d;
      err_range_q   <= err_range_d;
    end
  end

  assign flags       = flags_q;
  assign gnt_vld     = gnt_vld_q;
  assign gnt_id      = gnt_id_q;
  assign err_illegal = err_illegal_q;
  assign err_range   = err_range_q;

`ifdef SR_FLAG_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       hit_any;

  // A command raising both errors still counts once; err_clr restarts the count from this edge.
  always_comb begin
    hit_any   = hit_ill | hit_rng;
    err_cnt_d = err_clr ? 8'd0 : err_cnt_q;
    if (hit_any && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter (N_FLAG=6 so out-of-range indices exist): directed cases plus random traffic
// against a distance-based round-robin reference model.
module tb_sr_flag_arbiter;
  localparam int N  = 4;
  localparam int NF = 6;
  localparam int IW = 3;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_set, req_clr, req_ready;
  logic [N*IW-1:0] req_idx;
  logic            err_clr;
  logic [NF-1:0]   flags;
  logic            gnt_vld;
  logic [GW-1:0]   gnt_id;
  logic            err_illegal, err_range;
`ifdef SR_FLAG_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  sr_flag_arbiter #(.N_REQ(N), .N_FLAG(NF), .IDX_W(IW), .GNT_W(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_set(req_set), .req_clr(req_clr), .req_idx(req_idx),
    .req_ready(req_ready), .err_clr(err_clr), .flags(flags),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id),
    .err_illegal(err_illegal), .err_range(err_range)
`ifdef SR_FLAG_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int         m_last;
  bit [NF-1:0] m_flags;
  bit         m_vld;
  int         m_id;
  bit         m_ill, m_rng;
  int         m_cnt;

  function automatic void mdl_reset();
    m_last = N - 1; m_flags = '0; m_vld = 0; m_id = 0; m_ill = 0; m_rng = 0; m_cnt = 0;
  endfunction

  // Winner = valid requester with the smallest round-robin distance past the last grant.
  function automatic int mdl_winner();
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i - m_last - 1 + 2 * N) % N;
      if (req_valid[i] && d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  function automatic void mdl_edge(input int w);
    bit s, c, e_ill, e_rng;
    int ix;
    if (err_clr) begin m_ill = 0; m_rng = 0; m_cnt = 0; end
    if (w < 0) begin m_vld = 0; return; end
    s = req_set[w]; c = req_clr[w]; ix = int'(req_idx[w*IW +: IW]);
    e_ill = s && c;
    e_rng = ix >= NF;
    if (!e_ill && !e_rng) begin
      if (s) m_flags[ix] = 1'b1;
      else if (c) m_flags[ix] = 1'b0;
    end
    if (e_ill) m_ill = 1;
    if (e_rng) m_rng = 1;
    if (e_ill || e_rng) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    m_vld = 1; m_id = w; m_last = w;
  endfunction

  task automatic chk_state();
    chk("flags", 32'(flags), 32'(m_flags));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_vld));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("err_illegal", 32'(err_illegal), 32'(m_ill));
    chk("err_range", 32'(err_range), 32'(m_rng));
`ifdef SR_FLAG_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    int w;
    #1;
    w = mdl_winner();
    chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk);
    mdl_edge(w);
    @(negedge clk);
    chk_state();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_err_ill", 32'(err_illegal), 32'd0);
    chk("rst_err_rng", 32'(err_range), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input int i, input bit v, input bit s, input bit c, input int ix);
    req_valid[i]          = v;
    req_set[i]            = s;
    req_clr[i]            = c;
    req_idx[i*IW +: IW]   = IW'(ix);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_set = '0; req_clr = '0; req_idx = '0; err_clr = 1'b0;
    mdl_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk_state();
    cycle();

    // Single set from requester 0
    set_cmd(0, 1, 1, 0, 3);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    cycle();
    chk("single_flags", 32'(flags), 32'h08);
    chk("single_id", 32'(gnt_id), 32'd0);
    req_valid = '0;
    async_reset();

    // Fairness: all four valid, requester i sets flag i
    for (int i = 0; i < N; i++) set_cmd(i, 1, 1, 0, i);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("fair_id", 32'(gnt_id), 32'(k % N));
      if (k == 3) chk("fair_flags", 32'(flags), 32'h0F);
    end

    // Reset mid-stream with requests held
    async_reset();
    req_valid = '0;
    cycle();
    req_valid = '1;
    cycle();
    chk("post_rst_first", 32'(gnt_id), 32'd0);

    // Illegal set+clear leaves flag 2 alone
    req_valid = '0;
    set_cmd(2, 1, 1, 0, 2);
    cycle();
    req_valid = '0;
    set_cmd(1, 1, 1, 1, 2);
    cycle();
    chk("ill_flag2", 32'(flags[2]), 32'd1);
    chk("ill_err", 32'(err_illegal), 32'd1);
    req_valid = '0; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("ill_cleared", 32'(err_illegal), 32'd0);

    // Range errors, including one coinciding with err_clr
    set_cmd(0, 1, 1, 0, 7);
    cycle();
    chk("rng_err", 32'(err_range), 32'd1);
    err_clr = 1'b1;
    set_cmd(0, 1, 1, 0, 6);
    cycle();
    chk("rng_clr_same_edge", 32'(err_range), 32'd1);
    req_valid = '0;
    cycle();
    chk("rng_cleared", 32'(err_range), 32'd0);
    err_clr = 1'b0;

    // Clear and no-op commands
    req_valid = '0;
    set_cmd(3, 1, 0, 1, 2);
    cycle();
    set_cmd(3, 1, 0, 0, 0);
    cycle();
    req_valid = '0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom);
      req_set   = N'($urandom);
      req_clr   = N'($urandom);
      req_idx   = (N*IW)'($urandom);
      err_clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
